tone_decoder: RTL and testbench

//  Upstream feeder of the drive state machine's JUNCTION state. Qualifies the five

---
 rtl/tone_decoder_pkg.sv | 31 +++
 rtl/tone_decoder_qualifier.sv | 57 +++++
 rtl/tone_decoder.sv | 114 +++++++++++
 tb/tb_tone_decoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_decoder_pkg.sv
// rtl/tone_decoder_pkg.sv - shared direction/state encodings and qualifier-vector helpers
package tone_decoder_pkg;

    // Same encodings the drive FSM uses for its junction conditions.
    typedef enum logic [1:0] {
        DIR_STRAIGHT = 2'b00,
        DIR_LEFT     = 2'b01,
        DIR_RIGHT    = 2'b10,
        DIR_BACK     = 2'b11
    } td_dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_REARM = 2'b10
    } td_state_e;

    function automatic logic multi_hot(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

    function automatic td_dir_e dir_from_onehot(input logic [3:0] v);
        td_dir_e d;
        d = DIR_STRAIGHT;
        if (v[1]) d = DIR_LEFT;
        if (v[2]) d = DIR_RIGHT;
        if (v[3]) d = DIR_BACK;
        return d;
    endfunction

endpackage

// File: rtl/tone_decoder_qualifier.sv
// rtl/tone_decoder_qualifier.sv - synchroniser plus high/low run counters qualifying one tone channel
module tone_qualifier #(
    parameter int QUAL_CYCLES = 2_500_000,
    parameter int DROP_CYCLES = 50_000,
    parameter int CNT_W       = 28
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bp_i,
    output logic qual_o
);
    import tone_decoder_pkg::*;

    localparam logic [CNT_W-1:0] QUAL_C    = CNT_W'(QUAL_CYCLES);
    localparam logic [CNT_W-1:0] DROP_LAST = CNT_W'(DROP_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] lo_q, lo_d;
    logic             qual_q, qual_d;

    // Short low runs only pause the high count; a full drop run forgets the tone.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        qual_d = (hi_q == QUAL_C);
        if (s2_q) begin
            lo_d = '0;
            if (hi_q != QUAL_C) hi_d = hi_q + CNT_W'(1);
        end else if (lo_q == DROP_LAST) begin
            hi_d   = '0;
            lo_d   = '0;
            qual_d = 1'b0;
        end else begin
            lo_d = lo_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            qual_q <= 1'b0;
        end else begin
            s1_q   <= bp_i;
            s2_q   <= s1_q;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            qual_q <= qual_d;
        end
    end

    assign qual_o = qual_q;

endmodule

// File: rtl/tone_decoder.sv
// rtl/tone_decoder.sv - turns qualified band-pass tones into one held junction command for the drive FSM
module tone_decoder #(
    parameter int QUAL_CYCLES = 2_500_000,
    parameter int DROP_CYCLES = 50_000,
    parameter int HOLD_CYCLES = 250_000_000,
    parameter int CNT_W       = 28
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       bp1,
    input  logic       bp2,
    input  logic       bp3,
    input  logic       bp4,
    input  logic       bp5,
    input  logic       tdAck,
    output logic       tdEn,
    output logic [1:0] tdDir,
    output logic       tdConflict,
    output logic       tdCancel,
    output logic [4:0] toneLevel
);
    import tone_decoder_pkg::*;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [4:0] bp_vec;
    logic [4:0] qual;

    td_state_e        state_q, state_d;
    td_dir_e          dir_q, dir_d;
    logic             en_q, en_d;
    logic             conflict_q, conflict_d;
    logic             cancel_q, cancel_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    assign bp_vec = {bp5, bp4, bp3, bp2, bp1};

    for (genvar g = 0; g < 5; g++) begin : g_qual
        tone_qualifier #(
            .QUAL_CYCLES (QUAL_CYCLES),
            .DROP_CYCLES (DROP_CYCLES),
            .CNT_W       (CNT_W)
        ) u_qual (
            .clk    (clk),
            .rst_n  (rstN),
            .bp_i   (bp_vec[g]),
            .qual_o (qual[g])
        );
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        en_d       = en_q;
        conflict_d = 1'b0;
        cancel_d   = 1'b0;
        hold_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (qual[3:0] != 4'd0 && !multi_hot(qual[3:0]) && !qual[4]) begin
                    dir_d   = dir_from_onehot(qual[3:0]);
                    en_d    = 1'b1;
                    state_d = ST_HOLD;
                end else if (multi_hot(qual[3:0])) begin
                    conflict_d = 1'b1;
                    state_d    = ST_REARM;
                end else if (qual[4]) begin
                    state_d = ST_REARM;
                end
            end
            ST_HOLD: begin
                hold_d = hold_q + CNT_W'(1);
                // An acknowledge in the same cycle as a cancel means the command was used.
                if (tdAck) begin
                    en_d    = 1'b0;
                    state_d = ST_REARM;
                end else if (qual[4] || hold_q == HOLD_LAST) begin
                    en_d     = 1'b0;
                    cancel_d = 1'b1;
                    state_d  = ST_REARM;
                end
            end
            ST_REARM: begin
                if (qual == 5'd0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_STRAIGHT;
            en_q       <= 1'b0;
            conflict_q <= 1'b0;
            cancel_q   <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            en_q       <= en_d;
            conflict_q <= conflict_d;
            cancel_q   <= cancel_d;
            hold_q     <= hold_d;
        end
    end

    assign tdEn       = en_q;
    assign tdDir      = dir_q;
    assign tdConflict = conflict_q;
    assign tdCancel   = cancel_q;
    assign toneLevel  = qual;

endmodule

// File: tb/tb_tone_decoder.sv
// tb/tb_tone_decoder.sv - scoreboard bench for tone_decoder with short qualify/drop/hold windows
module tb_tone_decoder;

    localparam int EV_RISE = 0;
    localparam int EV_FALL = 1;
    localparam int EV_CONF = 2;
    localparam int EV_CANC = 3;

    typedef struct {
        int         kind;
        int         cyc;
        logic [1:0] dir;
    } evt_t;

    logic       clk = 1'b0;
    logic       rstN;
    logic       bp1, bp2, bp3, bp4, bp5;
    logic       tdAck;
    logic       tdEn;
    logic [1:0] tdDir;
    logic       tdConflict;
    logic       tdCancel;
    logic [4:0] toneLevel;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    evt_t exp_q[$];

    tone_decoder #(
        .QUAL_CYCLES (8),
        .DROP_CYCLES (3),
        .HOLD_CYCLES (20),
        .CNT_W       (28)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .bp1        (bp1),
        .bp2        (bp2),
        .bp3        (bp3),
        .bp4        (bp4),
        .bp5        (bp5),
        .tdAck      (tdAck),
        .tdEn       (tdEn),
        .tdDir      (tdDir),
        .tdConflict (tdConflict),
        .tdCancel   (tdCancel),
        .toneLevel  (toneLevel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        case (k)
            EV_RISE: return "en_rise";
            EV_FALL: return "en_fall";
            EV_CONF: return "conflict";
            default: return "cancel";
        endcase
    endfunction

    task automatic push(input int kind, input int at, input logic [1:0] dir);
        evt_t e;
        e.kind = kind;
        e.cyc  = at;
        e.dir  = dir;
        exp_q.push_back(e);
    endtask

    task automatic check_evt(input int kind, input logic [1:0] dir);
        evt_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: got event at cycle %0d dir=%0d, required no event",
                     ev_name(kind), cyc, dir);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || (kind == EV_RISE && e.dir != dir)) begin
                n_fail++;
                $display("FAIL event_%s: got %s at cycle %0d dir=%0d, required %s at cycle %0d dir=%0d",
                         ev_name(e.kind), ev_name(kind), cyc, dir, ev_name(e.kind), e.cyc, e.dir);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic monitor_loop();
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (tdEn && !prev_en) check_evt(EV_RISE, tdDir);
            if (!tdEn && prev_en) check_evt(EV_FALL, tdDir);
            if (tdConflict)       check_evt(EV_CONF, tdDir);
            if (tdCancel)         check_evt(EV_CANC, tdDir);
            prev_en = tdEn;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int c;
        rstN = 1'b0;
        {bp1, bp2, bp3, bp4, bp5} = 5'b0;
        tdAck = 1'b0;
        fork
            monitor_loop();
        join_none
        #1;
        chk("reset_tdEn", int'(tdEn), 0);
        chk("reset_tdDir", int'(tdDir), 0);
        chk("reset_conflict", int'(tdConflict), 0);
        chk("reset_cancel", int'(tdCancel), 0);
        chk("reset_toneLevel", int'(toneLevel), 0);
        step(3);
        rstN = 1'b1;
        step(3);

        // 1: bp2 command, ack 15 cycles after rise, tone outlives the ack
        c = cyc;
        push(EV_RISE, c + 12, 2'b01);
        push(EV_FALL, c + 28, 2'b01);
        bp2 = 1'b1;
        step(27);
        tdAck = 1'b1;
        step(1);
        tdAck = 1'b0;
        step(2);
        bp2 = 1'b0;
        chk("t1_dir_held_after_ack", int'(tdDir), 1);
        step(15);

        // 2a: two-cycle glitch delays qualification by two cycles
        c = cyc;
        push(EV_RISE, c + 14, 2'b10);
        push(EV_FALL, c + 17, 2'b10);
        bp3 = 1'b1;
        step(4);
        bp3 = 1'b0;
        step(2);
        bp3 = 1'b1;
        step(10);
        tdAck = 1'b1;
        step(1);
        tdAck = 1'b0;
        step(1);
        bp3 = 1'b0;
        step(15);

        // 2b: three-cycle low restarts qualification; 5+6 highs never qualify
        bp3 = 1'b1;
        step(5);
        bp3 = 1'b0;
        step(3);
        bp3 = 1'b1;
        step(6);
        chk("t2b_toneLevel", int'(toneLevel), 0);
        bp3 = 1'b0;
        step(15);

        // 3: bp1+bp4 conflict, bp4 lingers; no command until every tone drops
        c = cyc;
        push(EV_CONF, c + 12, 2'b00);
        bp1 = 1'b1;
        bp4 = 1'b1;
        step(12);
        chk("t3_toneLevel", int'(toneLevel), 5'b01001);
        bp1 = 1'b0;
        step(10);
        bp4 = 1'b0;
        step(15);

        // 4a: bp4 command times out after 20 cycles
        c = cyc;
        push(EV_RISE, c + 12, 2'b11);
        push(EV_FALL, c + 32, 2'b11);
        push(EV_CANC, c + 32, 2'b11);
        bp4 = 1'b1;
        step(35);
        bp4 = 1'b0;
        step(15);

        // 4b: bp5 qualifying during HOLD cancels the bp1 command
        c = cyc;
        push(EV_RISE, c + 12, 2'b00);
        push(EV_FALL, c + 25, 2'b00);
        push(EV_CANC, c + 25, 2'b00);
        bp1 = 1'b1;
        step(13);
        bp5 = 1'b1;
        step(13);
        bp1 = 1'b0;
        bp5 = 1'b0;
        step(15);

        // 5: ack and bp5 qualification in the same cycle; ack wins
        c = cyc;
        push(EV_RISE, c + 12, 2'b01);
        push(EV_FALL, c + 25, 2'b01);
        bp2 = 1'b1;
        step(13);
        bp5 = 1'b1;
        step(11);
        tdAck = 1'b1;
        step(1);
        tdAck = 1'b0;
        step(1);
        bp2 = 1'b0;
        bp5 = 1'b0;
        step(15);

        // 6: reset while holding, then requalify the still-present tone from zero
        c = cyc;
        push(EV_RISE, c + 12, 2'b11);
        push(EV_FALL, c + 14, 2'b00);
        push(EV_RISE, c + 28, 2'b11);
        push(EV_FALL, c + 31, 2'b11);
        bp4 = 1'b1;
        step(14);
        chk("t6_toneLevel_before_reset", int'(toneLevel), 5'b01000);
        rstN = 1'b0;
        #1;
        chk("t6_reset_tdEn", int'(tdEn), 0);
        chk("t6_reset_tdDir", int'(tdDir), 0);
        chk("t6_reset_toneLevel", int'(toneLevel), 0);
        step(2);
        rstN = 1'b1;
        step(14);
        tdAck = 1'b1;
        step(1);
        tdAck = 1'b0;
        step(1);
        bp4 = 1'b0;
        step(15);

        chk("pending_events", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
